pbit_sweep_sequencer: RTL and testbench

Synthesizable sweep sequencer and sample source for the p-bit network. It generates the round-robin per-p-bit update enables: each p-bit gets one slot of `CYCLES_PER_UPDATE` clocks. At the end of every full sweep it captures the network state, bit-reversed so that p-bit 0 lands in the MSB. Captured samples go out through a 2-deep valid/ready buffer, which replaces free-running clock division on the consumer side with an explicit, lossless-or-counted sample stream.

---
 rtl/pbit_pkg.sv | 24 ++
 rtl/sample_fifo2.sv | 71 +++++++
 rtl/pbit_sweep_sequencer.sv | 118 +++++++++++
 tb/tb_pbit_sweep_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/pbit_pkg.sv
// Shared constants and helpers for the p-bit network: default sweep geometry
// and the bit-reversal used when packing network state into samples.
package pbit_pkg;

    localparam int N_PBITS_DEF           = 8;
    localparam int CYCLES_PER_UPDATE_DEF = 3;

    // Widest network the bit_reverse helper supports.
    localparam int MAX_PBITS = 64;

    // Reverse the low n bits of v so bit i moves to bit n-1-i. The full word is
    // mirrored first, then shifted down so the result sits in the low n bits.
    function automatic logic [MAX_PBITS-1:0] bit_reverse(
        input logic [MAX_PBITS-1:0] v,
        input int unsigned          n
    );
        logic [MAX_PBITS-1:0] r;
        for (int i = 0; i < MAX_PBITS; i++) begin
            r[i] = v[MAX_PBITS-1-i];
        end
        return r >> (MAX_PBITS - n);
    endfunction

endpackage

// File: rtl/sample_fifo2.sv
// Two-entry valid/ready FIFO. The full flag already accounts for a pop on the
// same edge, so a push into a full buffer that is being drained is accepted.
module sample_fifo2 #(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         ready_i,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    output logic         full_o
);

    logic [1:0]   count_q, count_d;
    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    logic         pop;
    logic         push_acc;

    assign pop      = (count_q != 2'd0) && ready_i;
    assign full_o   = (count_q == 2'd2) && !pop;
    assign push_acc = push_i && !full_o;
    assign valid_o  = (count_q != 2'd0);
    assign data_o   = head_q;

    // Next-state for occupancy and the two storage slots; pop is applied before push.
    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case ({pop, push_acc})
            2'b11: begin
                if (count_q == 2'd1) begin
                    head_d = push_data_i;
                end else begin
                    head_d = tail_q;
                    tail_d = push_data_i;
                end
            end
            2'b10: begin
                head_d  = tail_q;
                count_d = count_q - 2'd1;
            end
            2'b01: begin
                if (count_q == 2'd0) begin
                    head_d = push_data_i;
                end else begin
                    tail_d = push_data_i;
                end
                count_d = count_q + 2'd1;
            end
            default: ;
        endcase
    end

    // Storage registers; reset empties the buffer and clears the visible head.
    always_ff @(posedge CLK) begin
        if (RST) begin
            count_q <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

endmodule

// File: rtl/pbit_sweep_sequencer.sv
// Round-robin update-enable generator for the p-bit network. Each p-bit gets a
// slot of CYCLES_PER_UPDATE clocks; at the end of each sweep (after burn-in)
// the bit-reversed network state is pushed into a 2-deep sample buffer.
module pbit_sweep_sequencer
    import pbit_pkg::*;
#(
    parameter int N_PBITS           = N_PBITS_DEF,
    parameter int CYCLES_PER_UPDATE = CYCLES_PER_UPDATE_DEF,
    parameter int BURN_IN           = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               run,
    input  logic [N_PBITS-1:0] state_in,
    output logic [N_PBITS-1:0] en,
    output logic               sample_valid,
    input  logic               sample_ready,
    output logic [N_PBITS-1:0] sample_data,
    output logic [31:0]        sweep_count,
    output logic [15:0]        drop_count,
    output logic               busy
);

    localparam int SLOT_W  = $clog2(N_PBITS);
    localparam int PHASE_W = $clog2(CYCLES_PER_UPDATE);

    logic                busy_q;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [PHASE_W-1:0]  phase_q, phase_d;
    logic [31:0]         sweep_q, sweep_d;
    logic [31:0]         burn_q, burn_d;
    logic [15:0]         drop_q, drop_d;
    logic                last_slot;
    logic                last_phase;
    logic                capture;
    logic                push;
    logic                fifo_full;
    logic [N_PBITS-1:0]  rev_state;

    assign last_slot  = (slot_q == SLOT_W'(N_PBITS - 1));
    assign last_phase = (phase_q == PHASE_W'(CYCLES_PER_UPDATE - 1));
    assign capture    = busy_q && last_slot && last_phase;
    assign rev_state  = N_PBITS'(bit_reverse(MAX_PBITS'(state_in), N_PBITS));

    assign busy        = busy_q;
    assign sweep_count = sweep_q;
    assign drop_count  = drop_q;

    // Slot/phase advance, sweep and burn-in accounting, push and drop decisions.
    always_comb begin
        slot_d  = slot_q;
        phase_d = phase_q;
        sweep_d = sweep_q;
        burn_d  = burn_q;
        drop_d  = drop_q;
        push    = 1'b0;
        if (busy_q) begin
            if (last_phase) begin
                phase_d = '0;
                slot_d  = last_slot ? '0 : slot_q + SLOT_W'(1);
            end else begin
                phase_d = phase_q + PHASE_W'(1);
            end
        end
        if (capture) begin
            sweep_d = sweep_q + 32'd1;
            if (burn_q == 32'(BURN_IN)) begin
                push = 1'b1;
            end else begin
                burn_d = burn_q + 32'd1;
            end
        end
        if (push && fifo_full && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end
    end

    // One-hot enable for the current slot, only in phase 0 of a running sweep.
    always_comb begin
        en = '0;
        if (busy_q && (phase_q == '0)) begin
            en[slot_q] = 1'b1;
        end
    end

    // Sequencer state registers; run is sampled into busy_q each edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            busy_q  <= 1'b0;
            slot_q  <= '0;
            phase_q <= '0;
            sweep_q <= '0;
            burn_q  <= '0;
            drop_q  <= '0;
        end else begin
            busy_q  <= run;
            slot_q  <= slot_d;
            phase_q <= phase_d;
            sweep_q <= sweep_d;
            burn_q  <= burn_d;
            drop_q  <= drop_d;
        end
    end

    sample_fifo2 #(
        .W(N_PBITS)
    ) u_fifo (
        .CLK        (CLK),
        .RST        (RST),
        .push_i     (push),
        .push_data_i(rev_state),
        .ready_i    (sample_ready),
        .valid_o    (sample_valid),
        .data_o     (sample_data),
        .full_o     (fifo_full)
    );

endmodule

// File: tb/tb_pbit_sweep_sequencer.sv
// Bench for pbit_sweep_sequencer: directed phases plus a randomized stretch,
// all outputs compared every cycle against a sweep-position reference model.
module tb_pbit_sweep_sequencer;

    localparam int N  = 8;
    localparam int C  = 3;
    localparam int BI = 4;
    localparam int SW = N * C;

    logic        CLK = 1'b0;
    logic        RST;
    logic        run;
    logic [7:0]  state_in;
    logic [7:0]  en;
    logic        sample_valid;
    logic        sample_ready;
    logic [7:0]  sample_data;
    logic [31:0] sweep_count;
    logic [15:0] drop_count;
    logic        busy;

    always #5 CLK = ~CLK;

    pbit_sweep_sequencer #(
        .N_PBITS          (N),
        .CYCLES_PER_UPDATE(C),
        .BURN_IN          (BI)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .run         (run),
        .state_in    (state_in),
        .en          (en),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .sample_data (sample_data),
        .sweep_count (sweep_count),
        .drop_count  (drop_count),
        .busy        (busy)
    );

    // Reference model: position within the sweep in clocks, queue of samples.
    int          m_pos;
    bit          m_busy;
    logic [31:0] m_sweeps;
    int          m_burn;
    int          m_drop;
    logic [7:0]  mq[$];

    int total = 0;
    int bad   = 0;

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[7-i] = v[i];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit pop;
        bit do_push;
        if (RST) begin
            m_pos = 0; m_busy = 0; m_sweeps = 0; m_burn = 0; m_drop = 0;
            mq.delete();
        end else begin
            pop     = (mq.size() > 0) && sample_ready;
            do_push = 0;
            if (m_busy) begin
                if (m_pos == SW - 1) begin
                    m_sweeps = m_sweeps + 32'd1;
                    if (m_burn == BI) begin
                        if (mq.size() - int'(pop) < 2) do_push = 1;
                        else if (m_drop < 16'hFFFF) m_drop++;
                    end else begin
                        m_burn++;
                    end
                end
                m_pos = (m_pos + 1) % SW;
            end
            if (pop) void'(mq.pop_front());
            if (do_push) mq.push_back(rev8(state_in));
            m_busy = run;
        end
    endtask

    task automatic check_all();
        logic [7:0] exp_en;
        exp_en = (m_busy && (m_pos % C == 0)) ? 8'(1 << (m_pos / C)) : 8'h00;
        chk("en", 32'(en), 32'(exp_en));
        chk("valid", 32'(sample_valid), 32'(mq.size() > 0));
        if (mq.size() > 0) chk("data", 32'(sample_data), 32'(mq[0]));
        chk("sweeps", sweep_count, m_sweeps);
        chk("drops", 32'(drop_count), 32'(m_drop));
        chk("busy", 32'(busy), 32'(m_busy));
    endtask

    task automatic cyc();
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
        check_all();
    endtask

    initial begin
        logic [7:0] s [4];
        int g;

        // Reset
        RST = 1'b1; run = 1'b0; sample_ready = 1'b0; state_in = 8'h00;
        cyc(); cyc();
        chk("rst_en", 32'(en), 32'h0);
        chk("rst_valid", 32'(sample_valid), 32'h0);
        chk("rst_data", 32'(sample_data), 32'h0);
        chk("rst_sweeps", sweep_count, 32'h0);

        // Enable sequence, burn-in and reversal
        RST = 1'b0; run = 1'b1; sample_ready = 1'b1; state_in = 8'h01;
        repeat (25) cyc();
        chk("sweep1", sweep_count, 32'd1);
        repeat (96) cyc();
        chk("burn_sweeps", sweep_count, 32'd5);
        chk("burn_first_valid", 32'(sample_valid), 32'd1);
        chk("rev_data", 32'(sample_data), 32'h80);
        cyc();

        // Backpressure over four sweeps
        sample_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            s[k] = 8'(($urandom & 32'hF0) | 32'(k + 1));
            state_in = s[k];
            repeat (SW) cyc();
        end
        chk("bp_drops", 32'(drop_count), 32'd2);
        chk("bp_head0", 32'(sample_data), 32'(rev8(s[0])));
        sample_ready = 1'b1;
        cyc();
        chk("bp_head1", 32'(sample_data), 32'(rev8(s[1])));
        cyc();
        chk("bp_drained", 32'(sample_valid), 32'd0);

        // Full buffer with a pop on the capture edge
        sample_ready = 1'b0;
        g = 0;
        while (!(mq.size() == 2 && m_pos == SW - 1 && m_busy) && g < 200) begin
            state_in = 8'($urandom);
            cyc();
            g++;
        end
        chk("full_wait_in_budget", 32'(g < 200), 32'd1);
        sample_ready = 1'b1;
        cyc();
        sample_ready = 1'b0;
        chk("full_pop_push_no_drop", 32'(drop_count), 32'd2);
        chk("full_pop_push_valid", 32'(sample_valid), 32'd1);
        cyc();

        // Randomized run / ready / state
        repeat (600) begin
            run          = ($urandom % 16) != 0;
            sample_ready = 1'($urandom);
            state_in     = 8'($urandom);
            cyc();
        end

        // Freeze at slot 3, phase 1 and resume
        run = 1'b1; sample_ready = 1'b1;
        g = 0;
        while (!(m_busy && m_pos == 3 * C + 1) && g < 100) begin
            state_in = 8'($urandom);
            cyc();
            g++;
        end
        chk("freeze_wait_in_budget", 32'(g < 100), 32'd1);
        run = 1'b0;
        cyc();
        for (int k = 0; k < 10; k++) begin
            cyc();
            chk("freeze_en", 32'(en), 32'h0);
        end
        run = 1'b1;
        g = 0;
        do begin
            cyc();
            g++;
        end while (en == 8'h00 && g < 30);
        chk("resume_en", 32'(en), 32'h10);

        // Reset mid-sweep with samples buffered and run held high
        sample_ready = 1'b0;
        repeat (60) begin
            state_in = 8'($urandom);
            cyc();
        end
        RST = 1'b1;
        cyc();
        chk("midrst_en", 32'(en), 32'h0);
        chk("midrst_valid", 32'(sample_valid), 32'h0);
        chk("midrst_data", 32'(sample_data), 32'h0);
        chk("midrst_sweeps", sweep_count, 32'h0);
        chk("midrst_drops", 32'(drop_count), 32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        RST = 1'b0; sample_ready = 1'b1;
        repeat (40) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
